// File: rtl/tlrot_mailbox.sv
// rtl/tlrot_mailbox.sv - TL-UL mailbox device; define TLROT_MBOX_PARTIAL_EN to accept PutPartialData
package tlul_pkg;
   localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
   localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
   localparam logic [2:0] GET              = 3'h4;
   localparam logic [2:0] ACCESS_ACK       = 3'h0;
   localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [0:0]  d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module tlrot_mailbox
   import tlul_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3B00_0000,
   parameter int          NUM_REGS  = 4
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  tl_h2d_t tl_i,
   output tl_d2h_t tl_o,
   output logic    done_o
);
   // Window is the next power of two covering DATA[], STATUS and INTR_EN.
   localparam int          AW         = $clog2(4*NUM_REGS+8);
   localparam int          IW         = AW-2;
   localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_REGS);
   localparam logic [IW-1:0] INTR_IDX   = IW'(NUM_REGS+1);
   localparam logic [31:0] REG_MASK   = 32'((64'd1 << NUM_REGS) - 64'd1);

   typedef enum logic {IDLE, RESP} state_e;
   state_e state_q, state_d;

   logic [31:0] data_q [NUM_REGS];
   logic [31:0] status_q, intr_en_q;
   logic        done_q;
   logic [2:0]  rsp_opcode_q;
   logic [1:0]  rsp_size_q;
   logic [7:0]  rsp_source_q;
   logic [31:0] rsp_data_q;
   logic        rsp_error_q;

   logic          is_get, op_ok, in_window, req_err, accept, do_write;
   logic [IW-1:0] idx;
   logic [31:0]   wmask, rdata;
   logic          unused_tl;

   assign unused_tl = ^{tl_i.a_param, tl_i.a_mask};
   assign idx       = tl_i.a_address[AW-1:2];
   assign in_window = (tl_i.a_address[31:AW] == BASE_ADDR[31:AW]);
   assign is_get    = (tl_i.a_opcode == GET);
`ifdef TLROT_MBOX_PARTIAL_EN
   assign op_ok = is_get || (tl_i.a_opcode == PUT_FULL_DATA) || (tl_i.a_opcode == PUT_PARTIAL_DATA);
   assign wmask = (tl_i.a_opcode == PUT_PARTIAL_DATA) ?
                  {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}}, {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}} :
                  32'hFFFF_FFFF;
`else
   assign op_ok = is_get || (tl_i.a_opcode == PUT_FULL_DATA);
   assign wmask = 32'hFFFF_FFFF;
`endif
   assign req_err  = !op_ok || (tl_i.a_size != 2'd2) || (tl_i.a_address[1:0] != 2'b00) ||
                     !in_window || (idx > INTR_IDX);
   assign accept   = (state_q == IDLE) && tl_i.a_valid;
   assign do_write = accept && !req_err && !is_get;

   // Read mux over the decoded register index.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx == IW'(i)) rdata = data_q[i];
      end
      if (idx == STATUS_IDX) rdata = status_q;
      if (idx == INTR_IDX)   rdata = intr_en_q;
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and D-channel drive; D fields come straight from the latched response.
   always_comb begin
      state_d          = state_q;
      tl_o             = '0;
      tl_o.d_opcode    = rsp_opcode_q;
      tl_o.d_size      = rsp_size_q;
      tl_o.d_source    = rsp_source_q;
      tl_o.d_data      = rsp_data_q;
      tl_o.d_error     = rsp_error_q;
      case (state_q)
         IDLE: begin
            tl_o.a_ready = 1'b1;
            if (tl_i.a_valid) state_d = RESP;
         end
         RESP: begin
            tl_o.d_valid = 1'b1;
            if (tl_i.d_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register side effects and response latch, both on the accept edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) data_q[i] <= '0;
         status_q     <= '0;
         intr_en_q    <= '0;
         rsp_opcode_q <= '0;
         rsp_size_q   <= '0;
         rsp_source_q <= '0;
         rsp_data_q   <= '0;
         rsp_error_q  <= 1'b0;
      end else begin
         if (do_write) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (idx == IW'(i)) begin
                  data_q[i] <= (data_q[i] & ~wmask) | (tl_i.a_data & wmask);
                  if (|wmask) status_q[i] <= 1'b1;
               end
            end
            if (idx == STATUS_IDX) status_q  <= status_q & ~(tl_i.a_data & wmask & REG_MASK);
            if (idx == INTR_IDX)   intr_en_q <= ((intr_en_q & ~wmask) | (tl_i.a_data & wmask)) & REG_MASK;
         end
         if (accept) begin
            rsp_opcode_q <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            rsp_size_q   <= tl_i.a_size;
            rsp_source_q <= tl_i.a_source;
            rsp_data_q   <= (is_get && !req_err) ? rdata : '0;
            rsp_error_q  <= req_err;
         end
      end
   end

   // Level interrupt, one cycle behind STATUS/INTR_EN.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) done_q <= 1'b0;
      else       done_q <= |(status_q & intr_en_q);
   end

   assign done_o = done_q;
endmodule

// File: tb/tb_tlrot_mailbox.sv
// tb/tb_tlrot_mailbox.sv - self-checking bench for tlrot_mailbox
module tb_tlrot_mailbox;
   import tlul_pkg::*;
   localparam logic [31:0] BASE = 32'h3B00_0000;

   logic    clk = 1'b0;
   logic    rst;
   tl_h2d_t tl_i;
   tl_d2h_t tl_o;
   logic    done_o;

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_data [4];
   logic [31:0] m_status, m_inten;
   logic        m_busy, done_exp, run;
   logic [2:0]  exp_op;
   logic        exp_err;
   logic [31:0] exp_data;
   logic [7:0]  exp_src;
   logic [1:0]  exp_size;
   logic [7:0]  src_ctr = 8'h10;
   logic [31:0] rd;
   logic        er;
`ifdef TLROT_MBOX_PARTIAL_EN
   localparam bit PARTIAL = 1'b1;
`else
   localparam bit PARTIAL = 1'b0;
`endif

   tlrot_mailbox #(.BASE_ADDR(BASE), .NUM_REGS(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .tl_i  (tl_i),
      .tl_o  (tl_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_data[i] = '0;
      m_status = '0; m_inten = '0; m_busy = 1'b0; done_exp = 1'b0;
   endtask

   // Specification-level model of one accepted request.
   task automatic model_accept();
      logic [31:0] off, bm, d;
      int          r;
      bit          inwin, ok, err;
      off   = tl_i.a_address - BASE;
      inwin = (tl_i.a_address >= BASE) && (off < 32);
      r     = int'(off / 4);
      d     = tl_i.a_data;
      ok    = (tl_i.a_opcode == 3'h4) || (tl_i.a_opcode == 3'h0) || (PARTIAL && tl_i.a_opcode == 3'h1);
      err   = !ok || tl_i.a_size != 2 || (tl_i.a_address % 4) != 0 || !inwin || r > 5;
      bm    = '0;
      for (int b = 0; b < 4; b++)
         if (tl_i.a_opcode != 3'h1 || tl_i.a_mask[b]) bm = bm | (32'hFF << (8*b));
      exp_op   = (tl_i.a_opcode == 3'h4) ? 3'h1 : 3'h0;
      exp_err  = err;
      exp_data = '0;
      exp_src  = tl_i.a_source;
      exp_size = tl_i.a_size;
      if (!err) begin
         if (tl_i.a_opcode == 3'h4) begin
            if (r < 4)       exp_data = m_data[r];
            else if (r == 4) exp_data = m_status;
            else             exp_data = m_inten;
         end else if (r < 4) begin
            m_data[r] = (m_data[r] & ~bm) | (d & bm);
            if (bm != 0) m_status[r] = 1'b1;
         end else if (r == 4) begin
            m_status = m_status & ~(d & bm);
         end else begin
            m_inten = ((m_inten & ~bm) | (d & bm)) & 32'hF;
         end
      end
      m_busy = 1'b1;
   endtask

   // Per-cycle comparison of DUT outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (run) begin
            chk("a_ready", 32'(tl_o.a_ready), 32'(!m_busy));
            chk("d_valid", 32'(tl_o.d_valid), 32'(m_busy));
            if (m_busy) begin
               chk("d_opcode", 32'(tl_o.d_opcode), 32'(exp_op));
               chk("d_error",  32'(tl_o.d_error),  32'(exp_err));
               chk("d_data",   tl_o.d_data,        exp_data);
               chk("d_source", 32'(tl_o.d_source), 32'(exp_src));
               chk("d_size",   32'(tl_o.d_size),   32'(exp_size));
               chk("d_param",  32'(tl_o.d_param),  32'(0));
               chk("d_sink",   32'(tl_o.d_sink),   32'(0));
            end
            chk("done_o", 32'(done_o), 32'(done_exp));
            done_exp = |(m_status & m_inten);
         end
      end
   end

   task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [1:0] sz, input int stall,
                       output logic [31:0] rdo, output logic ero);
      int          n;
      logic [31:0] first;
      @(negedge clk);
      tl_i.a_valid   = 1'b1;
      tl_i.a_opcode  = op;
      tl_i.a_address = addr;
      tl_i.a_data    = data;
      tl_i.a_mask    = mask;
      tl_i.a_size    = sz;
      tl_i.a_source  = src_ctr;
      src_ctr        = src_ctr + 8'd1;
      n = 0;
      while (!tl_o.a_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         failures++;
         $display("FAIL accept_timeout actual=busy required=a_ready");
         tl_i.a_valid = 1'b0;
         rdo = 'x; ero = 1'bx;
         return;
      end
      @(posedge clk);
      model_accept();
      @(negedge clk);
      tl_i.a_valid = 1'b0;
      first = tl_o.d_data;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk("stall_d_data", tl_o.d_data, first);
         chk("stall_a_ready", 32'(tl_o.a_ready), 32'(0));
      end
      rdo = tl_o.d_data;
      ero = tl_o.d_error;
      tl_i.d_ready = 1'b1;
      @(posedge clk);
      m_busy = 1'b0;
      @(negedge clk);
      tl_i.d_ready = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      tl_i = '0;
      run  = 1'b0;
      model_reset();
      #1;
      chk("rst_a_ready", 32'(tl_o.a_ready), 32'(1));
      chk("rst_d_valid", 32'(tl_o.d_valid), 32'(0));
      chk("rst_d_data",  tl_o.d_data,       32'(0));
      chk("rst_done",    32'(done_o),       32'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run = 1'b1;

      xact(GET, BASE, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("get0_data", rd, 32'h0);
      chk("get0_err", 32'(er), 32'(0));

      xact(PUT_FULL_DATA, BASE + 4, 32'hDEAD_BEEF, 4'hF, 2'd2, 0, rd, er);
      xact(GET, BASE + 4, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("get4_data", rd, 32'hDEAD_BEEF);
      xact(GET, BASE + 16, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("status_after_put", rd, 32'h2);

      xact(PUT_FULL_DATA, BASE + 20, 32'h2, 4'hF, 2'd2, 0, rd, er);
      @(negedge clk);
      chk("done_set", 32'(done_o), 32'(1));
      xact(PUT_FULL_DATA, BASE + 16, 32'h2, 4'hF, 2'd2, 0, rd, er);
      xact(GET, BASE + 16, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("status_w1c", rd, 32'h0);
      chk("done_clear", 32'(done_o), 32'(0));

      xact(GET, BASE + 4, 32'h0, 4'hF, 2'd2, 5, rd, er);
      chk("stall_get", rd, 32'hDEAD_BEEF);

      xact(GET, BASE + 32, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("oow_err", 32'(er), 32'(1));
      chk("oow_data", rd, 32'h0);
      xact(PUT_FULL_DATA, BASE, 32'h1234, 4'hF, 2'd1, 0, rd, er);
      chk("size1_err", 32'(er), 32'(1));
      xact(PUT_FULL_DATA, BASE + 2, 32'h5555, 4'hF, 2'd2, 0, rd, er);
      chk("misalign_err", 32'(er), 32'(1));
      xact(3'h2, BASE, 32'h7777, 4'hF, 2'd2, 0, rd, er);
      chk("badop_err", 32'(er), 32'(1));
      xact(GET, BASE + 24, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("hole_err", 32'(er), 32'(1));
      xact(GET, BASE + 256, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("far_err", 32'(er), 32'(1));
      xact(GET, BASE, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("data0_unchanged", rd, 32'h0);

      xact(PUT_FULL_DATA, BASE + 20, 32'hFFFF_FFFF, 4'hF, 2'd2, 0, rd, er);
      xact(GET, BASE + 20, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("intr_en_tied", rd, 32'hF);

      xact(PUT_FULL_DATA, BASE + 4, 32'hAAAA_AAAA, 4'hF, 2'd2, 0, rd, er);
      xact(PUT_PARTIAL_DATA, BASE + 4, 32'h1122_3344, 4'h3, 2'd2, 0, rd, er);
      chk("partial_err", 32'(er), PARTIAL ? 32'(0) : 32'(1));
      xact(GET, BASE + 4, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("partial_data", rd, PARTIAL ? 32'hAAAA_3344 : 32'hAAAA_AAAA);

      @(negedge clk);
      tl_i.a_valid   = 1'b1;
      tl_i.a_opcode  = GET;
      tl_i.a_address = BASE + 4;
      tl_i.a_size    = 2'd2;
      @(posedge clk);
      #2;
      tl_i.a_valid = 1'b0;
      run = 1'b0;
      chk("mid_dvalid_pre", 32'(tl_o.d_valid), 32'(1));
      rst = 1'b1;
      #1;
      chk("mid_dvalid_drop", 32'(tl_o.d_valid), 32'(0));
      chk("mid_a_ready", 32'(tl_o.a_ready), 32'(1));
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;
      xact(GET, BASE + 4, 32'h0, 4'hF, 2'd2, 0, rd, er);
      chk("post_rst_data", rd, 32'h0);
      chk("post_rst_done", 32'(done_o), 32'(0));

      run = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
